// File: rtl/gates_bist_pkg.sv
// Shared types and the reference behaviour of the gates block for the BIST sequencer.
package gates_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int NUM_OUTS = 5;

  // Position of each gates output inside the observed/expected/mismatch vectors
  localparam int BIT_C = 0;  // and
  localparam int BIT_D = 1;  // or
  localparam int BIT_E = 2;  // xor
  localparam int BIT_F = 3;  // not (~a)
  localparam int BIT_G = 4;  // nand

  localparam logic [1:0] VEC_LAST = 2'd3;

  // Returns {nand, not, xor, or, and} for the given stimulus pair
  function automatic logic [NUM_OUTS-1:0] golden(input logic a, input logic b);
    logic [NUM_OUTS-1:0] r;
    r        = '0;
    r[BIT_C] = a & b;
    r[BIT_D] = a | b;
    r[BIT_E] = a ^ b;
    r[BIT_F] = ~a;
    r[BIT_G] = ~(a & b);
    return r;
  endfunction

endpackage

// File: rtl/gates_bist_controller_golden.sv
// Combinational reference model of the gates block: stimulus in, expected outputs out.
module gates_golden
  import gates_bist_pkg::*;
(
  input  logic                a,
  input  logic                b,
  output logic [NUM_OUTS-1:0] expected
);

  assign expected = golden(a, b);

endmodule

// File: rtl/gates_bist_controller.sv
// BIST sequencer for the gates block: steps {a,b} through all four vectors,
// waits for the outputs to settle, compares against the golden model and
// reports pass/done, a saturating error count and sticky fault masks.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | waiting for start; results of the last run held
//  DRIVE  | register vec_idx onto a,b; load the settle timer
//  SETTLE | hold a,b for SETTLE_CYCLES cycles (down-counter)
//  CHECK  | compare c..g against golden(a,b); pick next vector/loop
//  DONE   | one-cycle done pulse, then back to IDLE
module gates_bist_controller
  import gates_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_mask,
  output logic [4:0]       mismatch_bits
);

  localparam int                   SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0]  SETTLE_TC   = SETTLE_W'(1);
  localparam int                   LOOP_W      = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [LOOP_W-1:0]    LOOP_LAST   = LOOP_W'(LOOPS - 1);
  localparam logic [ERR_W-1:0]     ERR_MAX     = '1;

  state_t                state;
  state_t                state_next;
  logic [1:0]            vec_idx;
  logic [LOOP_W-1:0]     loop_cnt;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [NUM_OUTS-1:0]   expected;
  logic [NUM_OUTS-1:0]   observed;
  logic [NUM_OUTS-1:0]   diff;
  logic                  any_diff;
  logic [ERR_W-1:0]      err_bumped;
  logic [ERR_W-1:0]      err_after;

  gates_golden u_golden (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // Pack the loopback inputs in the same bit order the golden model uses
  always_comb begin
    observed        = '0;
    observed[BIT_C] = c;
    observed[BIT_D] = d;
    observed[BIT_E] = e;
    observed[BIT_F] = f;
    observed[BIT_G] = g;
  end

  assign diff       = observed ^ expected;
  assign any_diff   = |diff;
  assign err_bumped = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
  // The pass decision must see the final CHECK's own update
  assign err_after  = any_diff ? err_bumped : err_count;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived status outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = DRIVE;
      end
      DRIVE: begin
        busy       = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_TC) state_next = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (vec_idx != VEC_LAST || loop_cnt != LOOP_LAST) begin
          state_next = DRIVE;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stimulus, timers, vector/loop indices and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      a             <= 1'b0;
      b             <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      fail_mask     <= '0;
      mismatch_bits <= '0;
      vec_idx       <= '0;
      loop_cnt      <= '0;
      settle_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pass          <= 1'b0;
            err_count     <= '0;
            fail_mask     <= '0;
            mismatch_bits <= '0;
            vec_idx       <= '0;
            loop_cnt      <= '0;
          end
        end
        DRIVE: begin
          a          <= vec_idx[1];
          b          <= vec_idx[0];
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt != SETTLE_TC) settle_cnt <= settle_cnt - 1'b1;
        end
        CHECK: begin
          if (any_diff) begin
            err_count          <= err_bumped;
            fail_mask[vec_idx] <= 1'b1;
            mismatch_bits      <= mismatch_bits | diff;
          end
          if (vec_idx != VEC_LAST) begin
            vec_idx <= vec_idx + 1'b1;
          end else if (loop_cnt != LOOP_LAST) begin
            vec_idx  <= '0;
            loop_cnt <= loop_cnt + 1'b1;
          end
          if (state_next == DONE) pass <= (err_after == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gates_bist_controller.sv
// Self-checking bench for gates_bist_controller: a faultable gates model in the
// loopback path, a time-offset behavioural model and per-cycle comparison.
module tb_gates_bist_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] fsel0, fsel1;   // 0 good, 1 c stuck-at-0, 2 f=b, 3 all inverted
  logic       cmp_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Gates block as seen by the controller, with an optional planted fault
  function automatic logic [4:0] gates_out(input logic [1:0] fs, input logic ga, input logic gb);
    logic [4:0] r;
    r = {~(ga & gb), ~ga, ga ^ gb, ga | gb, ga & gb};
    case (fs)
      2'd1: r[0] = 1'b0;
      2'd2: r[3] = gb;
      2'd3: r = ~r;
      default: ;
    endcase
    return r;
  endfunction

  // Truth of each gate from plain arithmetic on the 0/1 operands
  function automatic logic [4:0] ref_out(input int va, input int vb);
    logic [4:0] r;
    r[0] = (va * vb) == 1;
    r[1] = (va + vb) > 0;
    r[2] = (va + vb) == 1;
    r[3] = (va == 0);
    r[4] = (va * vb) != 1;
    return r;
  endfunction

  logic       a0, b0, busy0, done0, pass0, c0, d0, e0, f0, g0;
  logic [7:0] err0;
  logic [3:0] fmask0;
  logic [4:0] mbits0;
  logic       a1, b1, busy1, done1, pass1, c1, d1, e1, f1, g1;
  logic [1:0] err1;
  logic [3:0] fmask1;
  logic [4:0] mbits1;

  assign {g0, f0, e0, d0, c0} = gates_out(fsel0, a0, b0);
  assign {g1, f1, e1, d1, c1} = gates_out(fsel1, a1, b1);

  gates_bist_controller dut0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(fmask0), .mismatch_bits(mbits0)
  );

  gates_bist_controller #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(fmask1), .mismatch_bits(mbits1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance tracked by k = edges since the edge that accepted start.
  // A vector slot is SETTLE+2 cycles; vector j is driven at edge j*P+1 and judged at edge j*P+P.
  int m_per[2]  = '{4, 4};
  int m_loops[2] = '{1, 2};
  int m_emax[2] = '{255, 3};
  bit m_active[2];
  int m_k[2];
  int m_ab[2];
  int m_err[2];
  int m_fmask[2];
  int m_mbits[2];
  bit m_pass[2];

  always @(posedge clk) begin : model
    int p, n, vec;
    logic [1:0] fs, vbits;
    logic st;
    logic [4:0] obs, expv;
    for (int i = 0; i < 2; i++) begin
      p  = m_per[i];
      n  = 4 * m_loops[i] * p;
      st = start[i];
      fs = (i == 0) ? fsel0 : fsel1;
      if (rst) begin
        m_active[i] = 1'b0;
        m_k[i] = 0; m_ab[i] = 0; m_err[i] = 0;
        m_fmask[i] = 0; m_mbits[i] = 0; m_pass[i] = 1'b0;
      end else if (m_active[i]) begin
        m_k[i]++;
        if (m_k[i] <= n && (m_k[i] - 1) % p == 0) m_ab[i] = ((m_k[i] - 1) / p) % 4;
        if (m_k[i] <= n && m_k[i] % p == 0) begin
          vec   = (m_k[i] / p - 1) % 4;
          vbits = 2'(vec);
          obs   = gates_out(fs, vbits[1], vbits[0]);
          expv  = ref_out(vec / 2, vec % 2);
          if (obs != expv) begin
            if (m_err[i] < m_emax[i]) m_err[i]++;
            m_fmask[i] = m_fmask[i] | (1 << vec);
            m_mbits[i] = m_mbits[i] | int'(obs ^ expv);
          end
        end
        if (m_k[i] == n) m_pass[i] = (m_err[i] == 0);
        if (m_k[i] == n + 1) m_active[i] = 1'b0;
      end else if (st) begin
        m_active[i] = 1'b1;
        m_k[i] = 0; m_err[i] = 0; m_fmask[i] = 0; m_mbits[i] = 0; m_pass[i] = 1'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("a0",     32'(a0),     32'(m_ab[0] / 2));
      check("b0",     32'(b0),     32'(m_ab[0] % 2));
      check("busy0",  32'(busy0),  32'(m_active[0] && m_k[0] < 16));
      check("done0",  32'(done0),  32'(m_active[0] && m_k[0] == 16));
      check("pass0",  32'(pass0),  32'(m_pass[0]));
      check("err0",   32'(err0),   32'(m_err[0]));
      check("fmask0", 32'(fmask0), 32'(m_fmask[0]));
      check("mbits0", 32'(mbits0), 32'(m_mbits[0]));
      check("a1",     32'(a1),     32'(m_ab[1] / 2));
      check("b1",     32'(b1),     32'(m_ab[1] % 2));
      check("busy1",  32'(busy1),  32'(m_active[1] && m_k[1] < 32));
      check("done1",  32'(done1),  32'(m_active[1] && m_k[1] == 32));
      check("pass1",  32'(pass1),  32'(m_pass[1]));
      check("err1",   32'(err1),   32'(m_err[1]));
      check("fmask1", 32'(fmask1), 32'(m_fmask[1]));
      check("mbits1", 32'(mbits1), 32'(m_mbits[1]));
    end
  end

  function automatic logic done_of(input int inst);
    return (inst == 0) ? done0 : done1;
  endfunction

  // Wait for done; lat = 0 is the cycle right after the accepting edge
  task automatic wait_done(input int inst, output int lat);
    lat = 0;
    while (!done_of(inst) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_done%0d: got no done expected done within 100 cycles", inst);
    end
  endtask

  task automatic run_once(input int inst, output int lat);
    @(negedge clk);
    start[inst] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[inst] = 1'b0;
    wait_done(inst, lat);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin : stim
    int lat, gap, idle;
    rst   = 1'b1;
    start = 2'b00;
    fsel0 = 2'd0;
    fsel1 = 2'd3;
    @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_ab",    32'({a0, b0}), 32'd0);
    check("rst_busy",  32'(busy0),    32'd0);
    check("rst_pass",  32'(pass0),    32'd0);
    check("rst_err",   32'(err0),     32'd0);
    check("rst_masks", 32'({fmask0, mbits0}), 32'd0);

    // 1: good gates, default parameters
    fsel0 = 2'd0;
    run_once(0, lat);
    check("t1_latency", 32'(lat),    32'd16);
    check("t1_pass",    32'(pass0),  32'd1);
    check("t1_err",     32'(err0),   32'd0);
    check("t1_masks",   32'({fmask0, mbits0}), 32'd0);
    @(negedge clk);
    check("t1_ab_hold", 32'({a0, b0}), 32'd3);

    // 2: c stuck-at-0
    fsel0 = 2'd1;
    run_once(0, lat);
    check("t2_err",   32'(err0),   32'd1);
    check("t2_fmask", 32'(fmask0), 32'h8);
    check("t2_mbits", 32'(mbits0), 32'h01);
    check("t2_pass",  32'(pass0),  32'd0);

    // 3: f wired to b
    fsel0 = 2'd2;
    run_once(0, lat);
    check("t3_err",   32'(err0),   32'd2);
    check("t3_fmask", 32'(fmask0), 32'h9);
    check("t3_mbits", 32'(mbits0), 32'h08);
    check("t3_pass",  32'(pass0),  32'd0);

    // 4: reset during SETTLE of vector 2, then a clean run
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("t4_pre_ab",  32'({a0, b0}), 32'd2);
    check("t4_pre_err", 32'(err0),     32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t4_ab",   32'({a0, b0}), 32'd0);
    check("t4_busy", 32'(busy0),    32'd0);
    check("t4_err",  32'(err0),     32'd0);
    check("t4_mask", 32'({fmask0, mbits0}), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_no_done", 32'(done0), 32'd0);
    end
    fsel0 = 2'd0;
    run_once(0, lat);
    check("t4_latency", 32'(lat),   32'd16);
    check("t4_pass",    32'(pass0), 32'd1);

    // 5: two loops, all outputs inverted, 2-bit saturating count
    fsel1 = 2'd3;
    run_once(1, lat);
    check("t5_latency", 32'(lat),    32'd32);
    check("t5_err",     32'(err1),   32'd3);
    check("t5_fmask",   32'(fmask1), 32'hF);
    check("t5_mbits",   32'(mbits1), 32'h1F);
    check("t5_pass",    32'(pass1),  32'd0);

    // 6: pulse while busy is ignored; held start gives back-to-back runs
    fsel0 = 2'd0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, lat);
    check("t6_latency", 32'(lat + 6), 32'd16);
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(0, lat);
    check("t6_held_first", 32'(lat), 32'd16);
    gap  = 0;
    idle = 0;
    @(negedge clk);
    gap++;
    while (!done0 && gap < 100) begin
      if (!busy0 && !done0) idle++;
      @(negedge clk);
      gap++;
    end
    start[0] = 1'b0;
    check("t6_gap",  32'(gap),  32'd18);
    check("t6_idle", 32'(idle), 32'd1);
    check("t6_pass", 32'(pass0), 32'd1);
    repeat (4) @(negedge clk);
    check("t6_stop", 32'(busy0), 32'd0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
